prio_intr_ctrl: RTL

Parametrised, APB-programmable priority interrupt controller, the next generation of the team's `intr_ctrl`. It collects `NUM_PERIPHERALS` request lines and applies a per-source enable mask and a per-source level/edge mode. It arbitrates by programmable priority, breaking ties round-robin, and presents one winner to the master through a valid/serviced handshake. It sits between the peripheral request lines and the master's interrupt input, and is configured over the same single-phase APB-style register port as its predecessor.

---
 rtl/prio_intr_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/prio_intr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prio_intr_ctrl
//  Description : APB-programmable priority interrupt controller with per-source
//                mask, level/edge mode and round-robin tie breaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_intr_ctrl #(
    parameter int NUM_PERIPHERALS = 16,
    parameter int PRIO_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int IDX_WIDTH       = $clog2(NUM_PERIPHERALS),
    parameter int ADDR_WIDTH      = IDX_WIDTH + 2
) (
    input  logic                       pclk,
    input  logic                       prst,
    input  logic [ADDR_WIDTH-1:0]      paddr,
    input  logic                       pwrite,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic                       penable,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pready,
    output logic                       perror,
    input  logic [NUM_PERIPHERALS-1:0] intr_active,
    output logic                       intr_valid,
    output logic [IDX_WIDTH-1:0]       intr_to_service,
    input  logic                       intr_serviced
);

    localparam logic [2:0] c_sel_prio = 3'd0;
    localparam logic [2:0] c_sel_mask = 3'd1;
    localparam logic [2:0] c_sel_edge = 3'd2;
    localparam logic [2:0] c_sel_pend = 3'd3;
    localparam logic [2:0] c_sel_stat = 3'd4;
    localparam logic [2:0] c_sel_none = 3'd7;

    typedef enum logic {BIDLE, BACC} bus_state_t;
    typedef enum logic {ARB, SERV}   svc_state_t;

    function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [1:0]  region;
        logic [31:0] off;
        region = a[ADDR_WIDTH-1:IDX_WIDTH];
        off    = 32'(a[IDX_WIDTH-1:0]);
        decode = c_sel_none;
        if (region == 2'd0) begin
            if (off < 32'(NUM_PERIPHERALS)) decode = c_sel_prio;
        end else if (region == 2'd1) begin
            case (off)
                32'd0:   decode = c_sel_mask;
                32'd1:   decode = c_sel_edge;
                32'd2:   decode = c_sel_pend;
                32'd3:   decode = c_sel_stat;
                default: decode = c_sel_none;
            endcase
        end
    endfunction

    bus_state_t                 bus_state_q, bus_state_d;
    logic                       pready_q, pready_d;
    logic                       perror_q, perror_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic [ADDR_WIDTH-1:0]      acc_addr_q, acc_addr_d;
    logic [DATA_WIDTH-1:0]      acc_wdata_q, acc_wdata_d;
    logic                       acc_write_q, acc_write_d;
    logic                       acc_err_q, acc_err_d;

    logic [PRIO_WIDTH-1:0]      prio_q [NUM_PERIPHERALS];
    logic [PRIO_WIDTH-1:0]      prio_d [NUM_PERIPHERALS];
    logic [NUM_PERIPHERALS-1:0] mask_q, mask_d;
    logic [NUM_PERIPHERALS-1:0] edge_q, edge_d;
    logic [NUM_PERIPHERALS-1:0] pending_q, pending_d;
    logic [NUM_PERIPHERALS-1:0] prev_q, prev_d;

    svc_state_t                 svc_state_q, svc_state_d;
    logic                       intr_valid_q, intr_valid_d;
    logic [IDX_WIDTH-1:0]       svc_idx_q, svc_idx_d;
    logic [IDX_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;

    logic [2:0]                 w_live_sel;
    logic [2:0]                 w_acc_sel;
    logic                       w_live_err;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_commit;
    logic [NUM_PERIPHERALS-1:0] w_w1c;
    logic [NUM_PERIPHERALS-1:0] w_svc_onehot;
    logic [NUM_PERIPHERALS-1:0] w_svc_clr;
    logic [NUM_PERIPHERALS-1:0] w_elig;
    logic                       w_found;
    logic [PRIO_WIDTH-1:0]      w_best;
    logic [IDX_WIDTH-1:0]       w_win;
    logic                       w_unused_wdata;

    assign w_live_sel     = decode(paddr);
    assign w_acc_sel      = decode(acc_addr_q);
    assign w_live_err     = (w_live_sel == c_sel_none) || ((w_live_sel == c_sel_stat) && pwrite);
    assign w_unused_wdata = ^acc_wdata_q;

    always_comb begin
        w_rd_data = '0;
        case (w_live_sel)
            c_sel_prio: w_rd_data = DATA_WIDTH'(prio_q[paddr[IDX_WIDTH-1:0]]);
            c_sel_mask: w_rd_data = DATA_WIDTH'(mask_q);
            c_sel_edge: w_rd_data = DATA_WIDTH'(edge_q);
            c_sel_pend: w_rd_data = DATA_WIDTH'(pending_q);
            c_sel_stat: w_rd_data = DATA_WIDTH'({intr_valid_q, svc_idx_q});
            default:    w_rd_data = '0;
        endcase
    end

    // The transfer is captured on entry to BACC so the master may release the
    // bus as soon as it sees pready; the write itself lands at the end of BACC.
    always_comb begin
        bus_state_d = bus_state_q;
        pready_d    = 1'b0;
        perror_d    = 1'b0;
        prdata_d    = '0;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        acc_write_d = acc_write_q;
        acc_err_d   = acc_err_q;
        w_commit    = 1'b0;
        case (bus_state_q)
            BIDLE: begin
                if (penable) begin
                    bus_state_d = BACC;
                    pready_d    = 1'b1;
                    perror_d    = w_live_err;
                    prdata_d    = (!pwrite && !w_live_err) ? w_rd_data : '0;
                    acc_addr_d  = paddr;
                    acc_wdata_d = pwdata;
                    acc_write_d = pwrite;
                    acc_err_d   = w_live_err;
                end
            end
            BACC: begin
                bus_state_d = BIDLE;
                w_commit    = acc_write_q && !acc_err_q;
            end
            default: bus_state_d = BIDLE;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        mask_d = mask_q;
        edge_d = edge_q;
        w_w1c  = '0;
        if (w_commit) begin
            case (w_acc_sel)
                c_sel_prio: prio_d[acc_addr_q[IDX_WIDTH-1:0]] = acc_wdata_q[PRIO_WIDTH-1:0];
                c_sel_mask: mask_d = acc_wdata_q[NUM_PERIPHERALS-1:0];
                c_sel_edge: edge_d = acc_wdata_q[NUM_PERIPHERALS-1:0];
                c_sel_pend: w_w1c  = acc_wdata_q[NUM_PERIPHERALS-1:0];
                default: ;
            endcase
        end
    end

    assign w_svc_onehot = {{(NUM_PERIPHERALS-1){1'b0}}, 1'b1} << svc_idx_q;
    assign w_svc_clr    = ((svc_state_q == SERV) && intr_serviced) ? w_svc_onehot : '0;

    // Edge sources: a new rising edge in the same cycle beats any clear.
    always_comb begin
        prev_d    = intr_active;
        pending_d = '0;
        for (int i = 0; i < NUM_PERIPHERALS; i++) begin
            if (edge_q[i])
                pending_d[i] = (intr_active[i] & ~prev_q[i]) |
                               (pending_q[i] & ~w_svc_clr[i] & ~w_w1c[i]);
            else
                pending_d[i] = intr_active[i];
        end
    end

    assign w_elig = pending_q & mask_q & ~(intr_valid_q ? w_svc_onehot : '0);

    // Scan starts just after rr_ptr; a strictly greater priority is needed to
    // displace an earlier candidate, so ties resolve in cyclic order.
    always_comb begin
        logic [IDX_WIDTH:0] j;
        w_found = 1'b0;
        w_best  = '0;
        w_win   = '0;
        j       = '0;
        for (int k = 1; k <= NUM_PERIPHERALS; k++) begin
            j = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(k);
            if (j >= (IDX_WIDTH+1)'(NUM_PERIPHERALS))
                j = j - (IDX_WIDTH+1)'(NUM_PERIPHERALS);
            if (w_elig[j[IDX_WIDTH-1:0]] &&
                (!w_found || (prio_q[j[IDX_WIDTH-1:0]] > w_best))) begin
                w_found = 1'b1;
                w_best  = prio_q[j[IDX_WIDTH-1:0]];
                w_win   = j[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        svc_state_d  = svc_state_q;
        intr_valid_d = intr_valid_q;
        svc_idx_d    = svc_idx_q;
        rr_ptr_d     = rr_ptr_q;
        case (svc_state_q)
            ARB: begin
                if (w_found) begin
                    svc_idx_d    = w_win;
                    intr_valid_d = 1'b1;
                    svc_state_d  = SERV;
                end
            end
            SERV: begin
                if (intr_serviced) begin
                    intr_valid_d = 1'b0;
                    rr_ptr_d     = svc_idx_q;
                    svc_state_d  = ARB;
                end
            end
            default: svc_state_d = ARB;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            bus_state_q  <= BIDLE;
            pready_q     <= 1'b0;
            perror_q     <= 1'b0;
            prdata_q     <= '0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            acc_write_q  <= 1'b0;
            acc_err_q    <= 1'b0;
            for (int i = 0; i < NUM_PERIPHERALS; i++) prio_q[i] <= '0;
            mask_q       <= '1;
            edge_q       <= '0;
            pending_q    <= '0;
            prev_q       <= '0;
            svc_state_q  <= ARB;
            intr_valid_q <= 1'b0;
            svc_idx_q    <= '0;
            rr_ptr_q     <= IDX_WIDTH'(NUM_PERIPHERALS-1);
        end else begin
            bus_state_q  <= bus_state_d;
            pready_q     <= pready_d;
            perror_q     <= perror_d;
            prdata_q     <= prdata_d;
            acc_addr_q   <= acc_addr_d;
            acc_wdata_q  <= acc_wdata_d;
            acc_write_q  <= acc_write_d;
            acc_err_q    <= acc_err_d;
            prio_q       <= prio_d;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            pending_q    <= pending_d;
            prev_q       <= prev_d;
            svc_state_q  <= svc_state_d;
            intr_valid_q <= intr_valid_d;
            svc_idx_q    <= svc_idx_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign prdata          = prdata_q;
    assign pready          = pready_q;
    assign perror          = perror_q;
    assign intr_valid      = intr_valid_q;
    assign intr_to_service = svc_idx_q;

endmodule
`default_nettype wire
